// File: rtl/aes_stream_ctrl_pkg.sv
// Shared types and block geometry for the AES-128 word-serial stream controller.
package aes_stream_ctrl_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DRAIN
  } state_t;

  // New words enter at the bottom so the first word ends up in the MSW slot.
  function automatic logic [BLOCK_W-1:0] shift_in_word(input logic [BLOCK_W-1:0] blk,
                                                       input logic [WORD_W-1:0]  word);
    return {blk[BLOCK_W-WORD_W-1:0], word};
  endfunction

endpackage

// File: rtl/aes_block_serializer.sv
// Holds one 128-bit result block and presents it as four valid/ready words, MSW first.
module aes_block_serializer
  import aes_stream_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [BLOCK_W-1:0] i_block,
  input  logic               i_m_ready,
  output logic               o_m_valid,
  output logic [WORD_W-1:0]  o_m_data,
  output logic               o_m_last,
  output logic               o_done
);

  logic [BLOCK_W-1:0] r_buf;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_valid;
  logic               w_fire;
  logic               w_last_word;

  assign w_fire      = r_valid & i_m_ready;
  assign w_last_word = (r_out_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

  // The buffer shifts up one word per handshake, so the head word is always the top slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf     <= '0;
      r_out_cnt <= '0;
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_buf     <= i_block;
      r_out_cnt <= '0;
      r_valid   <= 1'b1;
    end else if (w_fire) begin
      r_buf     <= {r_buf[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
      r_out_cnt <= r_out_cnt + CNT_W'(1);
      if (w_last_word) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_m_valid = r_valid;
  assign o_m_data  = r_buf[BLOCK_W-1 -: WORD_W];
  assign o_m_last  = r_valid & w_last_word;
  assign o_done    = w_fire & w_last_word;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Word-serial front/back end for an iterative AES-128 core: key port, plaintext
// assembly, launch, completion watchdog and ciphertext drain.
module aes_stream_ctrl
  import aes_stream_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_key_we,
  input  logic [1:0]         i_key_idx,
  input  logic [DATA_W-1:0]  i_key_data,
  input  logic               i_s_valid,
  output logic               o_s_ready,
  input  logic [DATA_W-1:0]  i_s_data,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic [DATA_W-1:0]  o_m_data,
  output logic               o_m_last,
  output logic [BLOCK_W-1:0] o_core_plaintext,
  output logic [BLOCK_W-1:0] o_core_key,
  output logic               o_core_start,
  input  logic [BLOCK_W-1:0] i_core_cipher,
  input  logic               i_core_ready,
  output logic               o_busy,
  output logic               o_key_loaded,
  output logic               o_err_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t                     r_state;
  logic [WORD_W-1:0]          r_key_words [WORDS_PER_BLOCK];
  logic [WORDS_PER_BLOCK-1:0] r_key_mask;
  logic [BLOCK_W-1:0]         r_in_buf;
  logic [CNT_W-1:0]           r_word_cnt;
  logic [BLOCK_W-1:0]         r_op_pt;
  logic [BLOCK_W-1:0]         r_op_key;
  logic [TMR_W-1:0]           r_timer;
  logic                       r_err;
  logic                       r_core_start;

  logic [BLOCK_W-1:0]         w_key_flat;
  logic                       w_s_fire;
  logic                       w_load;
  logic                       w_drain_done;

  // Key words may be written in any state; the running block uses its own snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        r_key_words[i] <= '0;
      end
      r_key_mask <= '0;
    end else if (i_key_we) begin
      r_key_words[i_key_idx] <= i_key_data;
      r_key_mask[i_key_idx]  <= 1'b1;
    end
  end

  assign w_key_flat   = {r_key_words[0], r_key_words[1], r_key_words[2], r_key_words[3]};
  assign o_key_loaded = &r_key_mask;
  assign o_s_ready    = (r_state == IDLE) & o_key_loaded;
  assign w_s_fire     = i_s_valid & o_s_ready;
  assign w_load       = (r_state == WAIT) & i_core_ready;

  // The timeout compare fires one cycle early so err_timeout is visible exactly
  // TIMEOUT cycles after core_start; a same-cycle core_ready still takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_in_buf     <= '0;
      r_word_cnt   <= '0;
      r_op_pt      <= '0;
      r_op_key     <= '0;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s_fire) begin
            r_in_buf   <= shift_in_word(r_in_buf, i_s_data);
            r_word_cnt <= r_word_cnt + CNT_W'(1);
            if (r_word_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
              r_op_pt      <= shift_in_word(r_in_buf, i_s_data);
              r_op_key     <= w_key_flat;
              r_core_start <= 1'b1;
              r_state      <= START;
            end
          end
        end
        START: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          if (i_core_ready) begin
            r_state <= DRAIN;
          end else if (r_timer == TMR_W'(TIMEOUT - 2)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  aes_block_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_block   (i_core_cipher),
    .i_m_ready (i_m_ready),
    .o_m_valid (o_m_valid),
    .o_m_data  (o_m_data),
    .o_m_last  (o_m_last),
    .o_done    (w_drain_done)
  );

  assign o_core_plaintext = r_op_pt;
  assign o_core_key       = r_op_key;
  assign o_core_start     = r_core_start;
  assign o_busy           = (r_state != IDLE);
  assign o_err_timeout    = r_err;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench for aes_stream_ctrl with a behavioural core stub that answers
// FIPS-197 vectors exactly and a keyed mixing function for everything else.
module tb_aes_stream_ctrl;

  localparam int TIMEOUT = 16;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_key_we = 1'b0;
  logic [1:0]   i_key_idx = '0;
  logic [31:0]  i_key_data = '0;
  logic         i_s_valid = 1'b0;
  logic         o_s_ready;
  logic [31:0]  i_s_data = '0;
  logic         o_m_valid;
  logic         i_m_ready = 1'b0;
  logic [31:0]  o_m_data;
  logic         o_m_last;
  logic [127:0] o_core_plaintext;
  logic [127:0] o_core_key;
  logic         o_core_start;
  logic [127:0] i_core_cipher = '0;
  logic         i_core_ready = 1'b0;
  logic         o_busy;
  logic         o_key_loaded;
  logic         o_err_timeout;

  int total = 0;
  int bad = 0;
  int stub_delay = -1;
  int stub_cnt = 0;
  int start_count = 0;
  bit late_pulse = 1'b0;
  logic [127:0] stub_pt = '0;
  logic [127:0] stub_key = '0;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_key_we         (i_key_we),
    .i_key_idx        (i_key_idx),
    .i_key_data       (i_key_data),
    .i_s_valid        (i_s_valid),
    .o_s_ready        (o_s_ready),
    .i_s_data         (i_s_data),
    .o_m_valid        (o_m_valid),
    .i_m_ready        (i_m_ready),
    .o_m_data         (o_m_data),
    .o_m_last         (o_m_last),
    .o_core_plaintext (o_core_plaintext),
    .o_core_key       (o_core_key),
    .o_core_start     (o_core_start),
    .i_core_cipher    (i_core_cipher),
    .i_core_ready     (i_core_ready),
    .o_busy           (o_busy),
    .o_key_loaded     (o_key_loaded),
    .o_err_timeout    (o_err_timeout)
  );

  function automatic logic [127:0] oracle(input logic [127:0] pt, input logic [127:0] key);
    if (pt == C1_PT && key == C1_KEY) return C1_CT;
    if (pt == B_PT && key == B_KEY) return B_CT;
    return {pt[95:0], pt[127:96]} ^ key ^ 128'hdeadbeef_0badf00d_cafef00d_12345678;
  endfunction

  // Core stub: answers stub_delay cycles after the launch pulse; cipher is garbage otherwise.
  always @(negedge clk) begin
    i_core_ready  = 1'b0;
    i_core_cipher = {$urandom, $urandom, $urandom, $urandom};
    if (reset) begin
      stub_cnt = 0;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        i_core_ready  = 1'b1;
        i_core_cipher = oracle(stub_pt, stub_key);
      end
    end
    if (late_pulse) begin
      i_core_ready = 1'b1;
      late_pulse   = 1'b0;
    end
    if (!reset && o_core_start === 1'b1) begin
      start_count++;
      stub_pt  = o_core_plaintext;
      stub_key = o_core_key;
      if (stub_delay > 0) stub_cnt = stub_delay;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_key_we = 1'b0;
    i_s_valid = 1'b0;
    i_m_ready = 1'b0;
    late_pulse = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_key(input logic [1:0] idx, input logic [31:0] d);
    i_key_we = 1'b1;
    i_key_idx = idx;
    i_key_data = d;
    tick();
    i_key_we = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) write_key(2'(i), k[127-32*i -: 32]);
  endtask

  task automatic send_block(input logic [127:0] pt, output bit ok);
    int n;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      i_s_valid = 1'b1;
      i_s_data = pt[127-32*i -: 32];
      while (o_s_ready !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) ok = 1'b0;
      tick();
    end
    i_s_valid = 1'b0;
  endtask

  task automatic collect(output logic [127:0] data, output logic [3:0] lasts, output bit ok);
    int got;
    int n;
    got = 0;
    n = 0;
    data = '0;
    lasts = '0;
    i_m_ready = 1'b1;
    while (got < 4 && n < 200) begin
      if (o_m_valid === 1'b1) begin
        data[127-32*got -: 32] = o_m_data;
        lasts[got] = o_m_last;
        got++;
      end
      tick();
      n++;
    end
    ok = (got == 4);
    i_m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({o_s_ready, o_m_valid, o_m_last, o_core_start, o_busy, o_key_loaded, o_err_timeout} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b want=0000000",
               {o_s_ready, o_m_valid, o_m_last, o_core_start, o_busy, o_key_loaded, o_err_timeout});
    end
    total++;
    if (o_m_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_m_data got=%h want=0", o_m_data); end
    total++;
    if (o_core_plaintext !== 128'h0) begin bad++; $display("[TB] FAIL reset_core_pt got=%h want=0", o_core_plaintext); end
    total++;
    if (o_core_key !== 128'h0) begin bad++; $display("[TB] FAIL reset_core_key got=%h want=0", o_core_key); end
    reset = 1'b0;
  endtask

  task automatic test_fips_c1();
    bit ok;
    logic [127:0] data;
    logic [127:0] exp;
    logic [3:0] lasts;
    do_reset();
    load_key(C1_KEY);
    total++;
    if (o_key_loaded !== 1'b1) begin bad++; $display("[TB] FAIL c1_key_loaded got=%b want=1", o_key_loaded); end
    start_count = 0;
    stub_delay = 3;
    send_block(C1_PT, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL c1_accept got=stall want=4 accepts"); end
    collect(data, lasts, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL c1_drain got=timeout want=4 words"); end
    exp = C1_CT;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (data[127-32*i -: 32] !== exp[127-32*i -: 32]) begin
        bad++;
        $display("[TB] FAIL c1_word%0d got=%h want=%h", i, data[127-32*i -: 32], exp[127-32*i -: 32]);
      end
    end
    total++;
    if (lasts !== 4'b1000) begin bad++; $display("[TB] FAIL c1_last got=%b want=1000", lasts); end
    total++;
    if (start_count != 1) begin bad++; $display("[TB] FAIL c1_start_pulses got=%0d want=1", start_count); end
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL c1_idle_after got=%b want=0", o_busy); end
  endtask

  task automatic test_fips_b();
    bit ok;
    logic [127:0] data;
    logic [3:0] lasts;
    load_key(B_KEY);
    stub_delay = 7;
    send_block(B_PT, ok);
    collect(data, lasts, ok);
    total++;
    if (!ok || data !== B_CT) begin bad++; $display("[TB] FAIL b_cipher got=%h want=%h", data, B_CT); end
    total++;
    if (lasts !== 4'b1000) begin bad++; $display("[TB] FAIL b_last got=%b want=1000", lasts); end
  endtask

  task automatic test_no_key();
    bit seen;
    do_reset();
    start_count = 0;
    stub_delay = 2;
    write_key(2'd0, 32'h11111111);
    write_key(2'd1, 32'h22222222);
    write_key(2'd2, 32'h33333333);
    i_s_valid = 1'b1;
    i_s_data = 32'h12345678;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_s_ready !== 1'b0 || o_core_start !== 1'b0) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin bad++; $display("[TB] FAIL nokey_blocked got=ready/start seen want=none"); end
    total++;
    if (o_key_loaded !== 1'b0) begin bad++; $display("[TB] FAIL nokey_loaded got=%b want=0", o_key_loaded); end
    total++;
    if (start_count != 0) begin bad++; $display("[TB] FAIL nokey_starts got=%0d want=0", start_count); end
    i_key_we = 1'b1;
    i_key_idx = 2'd3;
    i_key_data = 32'h44444444;
    total++;
    if (o_s_ready !== 1'b0) begin bad++; $display("[TB] FAIL nokey_ready_early got=%b want=0", o_s_ready); end
    tick();
    i_key_we = 1'b0;
    i_s_valid = 1'b0;
    total++;
    if (o_s_ready !== 1'b1 || o_key_loaded !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nokey_ready_rise got=%b%b want=11", o_s_ready, o_key_loaded);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    bit hold_bad;
    int n;
    logic [127:0] data;
    logic [3:0] lasts;
    do_reset();
    load_key(C1_KEY);
    stub_delay = 4;
    send_block(C1_PT, ok);
    i_m_ready = 1'b0;
    n = 0;
    while (o_m_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    seen = (o_m_valid === 1'b1);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL bp_first_valid got=0 want=1"); end
    hold_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (o_m_valid !== 1'b1 || o_m_data !== 32'h69c4e0d8 || o_m_last !== 1'b0) hold_bad = 1'b1;
      tick();
    end
    total++;
    if (hold_bad) begin bad++; $display("[TB] FAIL bp_hold got=%b/%h want=1/69c4e0d8", o_m_valid, o_m_data); end
    collect(data, lasts, ok);
    total++;
    if (!ok || data !== C1_CT) begin bad++; $display("[TB] FAIL bp_words got=%h want=%h", data, C1_CT); end
    total++;
    if (lasts !== 4'b1000) begin bad++; $display("[TB] FAIL bp_last got=%b want=1000", lasts); end
    i_m_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_m_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    i_m_ready = 1'b0;
    total++;
    if (seen) begin bad++; $display("[TB] FAIL bp_extra_word got=valid want=none"); end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [127:0] data;
    logic [3:0] lasts;
    do_reset();
    load_key(C1_KEY);
    stub_delay = TIMEOUT - 1;
    send_block(C1_PT, ok);
    collect(data, lasts, ok);
    total++;
    if (!ok || data !== C1_CT) begin bad++; $display("[TB] FAIL to_late_ready got=%h want=%h", data, C1_CT); end
    total++;
    if (o_err_timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_late_ready_err got=%b want=0", o_err_timeout); end
    stub_delay = -1;
    send_block(C1_PT, ok);
    total++;
    if (o_core_start !== 1'b1) begin bad++; $display("[TB] FAIL to_start got=%b want=1", o_core_start); end
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    total++;
    if (o_err_timeout !== 1'b0 || o_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL to_early got=err%b busy%b want=err0 busy1", o_err_timeout, o_busy);
    end
    tick();
    total++;
    if (o_err_timeout !== 1'b1 || o_busy !== 1'b0 || o_s_ready !== 1'b1 || o_m_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL to_fire got=err%b busy%b rdy%b mv%b want=err1 busy0 rdy1 mv0",
               o_err_timeout, o_busy, o_s_ready, o_m_valid);
    end
    stub_delay = 2;
    send_block(C1_PT, ok);
    collect(data, lasts, ok);
    total++;
    if (!ok || data !== C1_CT) begin bad++; $display("[TB] FAIL to_recover got=%h want=%h", data, C1_CT); end
    total++;
    if (o_err_timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky got=%b want=1", o_err_timeout); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    bit seen;
    do_reset();
    load_key(C1_KEY);
    stub_delay = -1;
    send_block(C1_PT, ok);
    tick();
    tick();
    write_key(2'd0, 32'hffff0000);
    total++;
    if (o_core_key !== C1_KEY || o_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mw_key_snapshot got=%h busy%b want=%h busy1", o_core_key, o_busy, C1_KEY);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({o_s_ready, o_m_valid, o_m_last, o_core_start, o_busy, o_key_loaded, o_err_timeout} !== 7'b0 ||
        o_m_data !== 32'h0 || o_core_key !== 128'h0 || o_core_plaintext !== 128'h0) begin
      bad++;
      $display("[TB] FAIL mw_reset_outputs got=%b key=%h want=0000000 key=0",
               {o_s_ready, o_m_valid, o_m_last, o_core_start, o_busy, o_key_loaded, o_err_timeout}, o_core_key);
    end
    reset = 1'b0;
    late_pulse = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_m_valid !== 1'b0 || o_busy !== 1'b0) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin bad++; $display("[TB] FAIL mw_late_ready got=activity want=idle"); end
  endtask

  task automatic test_random_stream();
    localparam int NB = 6;
    logic [31:0]  mk [4];
    logic [31:0]  q [$];
    logic [127:0] cur_pt;
    logic [127:0] snap;
    logic [127:0] ct;
    bit inflight;
    int words_in;
    int out_idx;
    int blocks_out;
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mk[i] = $urandom;
      write_key(2'(i), mk[i]);
    end
    cur_pt = '0;
    inflight = 1'b0;
    words_in = 0;
    out_idx = 0;
    blocks_out = 0;
    n = 0;
    while (blocks_out < NB && n < 3000) begin
      total++;
      if (o_s_ready !== !inflight) begin
        bad++;
        $display("[TB] FAIL rnd_s_ready got=%b want=%b cycle=%0d", o_s_ready, !inflight, n);
      end
      i_m_ready = ($urandom_range(0, 3) != 0);
      if (o_m_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rnd_unexpected_word got=%h want=no word", o_m_data);
        end else begin
          total++;
          if (o_m_data !== q[0]) begin bad++; $display("[TB] FAIL rnd_data got=%h want=%h", o_m_data, q[0]); end
          total++;
          if (o_m_last !== (out_idx == 3)) begin
            bad++;
            $display("[TB] FAIL rnd_last got=%b want=%b", o_m_last, (out_idx == 3));
          end
          if (i_m_ready) begin
            void'(q.pop_front());
            out_idx++;
            if (out_idx == 4) begin
              out_idx = 0;
              inflight = 1'b0;
              blocks_out++;
            end
          end
        end
      end
      i_s_valid = 1'b0;
      if (words_in < 4 * NB && $urandom_range(0, 2) != 0) begin
        i_s_valid = 1'b1;
        i_s_data = $urandom;
      end
      snap = {mk[0], mk[1], mk[2], mk[3]};
      if (i_s_valid && o_s_ready === 1'b1) begin
        cur_pt = {cur_pt[95:0], i_s_data};
        words_in++;
        if (words_in % 4 == 0) begin
          ct = oracle(cur_pt, snap);
          for (int i = 0; i < 4; i++) q.push_back(ct[127-32*i -: 32]);
          inflight = 1'b1;
          stub_delay = $urandom_range(1, 12);
        end
      end
      i_key_we = ($urandom_range(0, 4) == 0);
      if (i_key_we) begin
        i_key_idx = 2'($urandom_range(0, 3));
        i_key_data = $urandom;
        mk[i_key_idx] = i_key_data;
      end
      tick();
      n++;
    end
    i_s_valid = 1'b0;
    i_key_we = 1'b0;
    i_m_ready = 1'b0;
    total++;
    if (blocks_out != NB) begin bad++; $display("[TB] FAIL rnd_blocks got=%0d want=%0d", blocks_out, NB); end
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_no_key();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=no finish want=finish");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
Word-serial front/back end for the iterative AES-128 encryption core.
- Loads a 128-bit key through a register-style write port.
- Assembles a 128-bit plaintext block from a 32-bit valid/ready input stream and launches the core with a one-cycle start pulse.
- Captures the ciphertext on the core's single-cycle ready pulse and drains it as four 32-bit words on a valid/ready output stream.
- Watchdog flags a core that never completes.

Parameters:
- DATA_W, 32: stream/key word width; fixed at 32, four words per block.
- TIMEOUT, 16: maximum cycles to wait for core_ready after core_start.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- key_we  in  1  key word write strobe
- key_idx  in  2  key word index; 0 maps to key[127:96], 3 to key[31:0]
- key_data  in  32  key word
- s_valid  in  1  plaintext word valid
- s_ready  out  1  plaintext word accept
- s_data  in  32  plaintext word; first word maps to [127:96]
- m_valid  out  1  ciphertext word valid
- m_ready  in  1  downstream accept
- m_data  out  32  ciphertext word; first word is [127:96]
- m_last  out  1  high with the 4th output word
- core_plaintext  out  128  operand to the core
- core_key  out  128  operand to the core
- core_start  out  1  one-cycle launch pulse
- core_cipher  in  128  core result, valid in the core_ready cycle
- core_ready  in  1  core completion pulse, one cycle
- busy  out  1  state != IDLE
- key_loaded  out  1  all four key words written since reset
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset:
  - All outputs 0, state IDLE.
  - Key register and key write mask cleared; word counters cleared.
  - Operand registers cleared; err_timeout cleared.
  - Reset mid-operation aborts the block; no output words are produced.
- Key port:
  - Writes are accepted in any state and set mask[key_idx].
  - key_loaded = &mask.
  - Rewriting an index overwrites the stored word.
- Operand snapshot:
  - core_plaintext and core_key come from operand registers, not the live key register.
  - Key writes during a block do not disturb the running encryption.
- State IDLE:
  - s_ready = key_loaded.
  - On each s_valid & s_ready, shift the word into the block buffer and increment word_cnt (0..3).
  - On the 4th accept, latch buffer→core_plaintext and the current key register→core_key, then go to START.
  - A key write in the same cycle as the 4th accept is not included in this block; the pre-write key is used.
- State START:
  - core_start = 1 for exactly this cycle; s_ready = 0.
  - Clear the timer; go to WAIT next cycle.
- State WAIT:
  - Timer increments every cycle.
  - If core_ready is high, capture core_cipher into the output buffer and go to DRAIN.
  - Otherwise, if timer reaches TIMEOUT, set err_timeout, drop the block and go to IDLE.
  - If core_ready and timeout occur in the same cycle, core_ready wins.
  - core_ready in any other state is ignored.
- State DRAIN:
  - m_valid = 1; m_data = word out_cnt of the buffer, MSW first.
  - m_last = (out_cnt == 3).
  - m_data, m_last and m_valid are held stable while m_ready = 0.
  - On handshake out_cnt increments; after the 4th handshake, go to IDLE.
  - s_ready = 0; no overlap of input collection and output drain.
- Latency:
  - START is the cycle after the 4th input accept.
  - The first m_valid is the cycle after core_ready.
- err_timeout is cleared only by reset; it does not block further operation.

Decomposition:
- Package aes_stream_ctrl_pkg holds:
  - state enum {IDLE, START, WAIT, DRAIN}
  - WORDS_PER_BLOCK = 4
  - BLOCK_W = 128
  - WORD_W = 32
- One natural sub-module: aes_block_serializer.
  - Holds the 128-bit output buffer, out_cnt, m_valid/m_data/m_last.
  - Load strobe driven from WAIT.

Test Plan:
- FIPS-197 C.1, real core attached:
  - Key words 00010203, 04050607, 08090a0b, 0c0d0e0f at idx 0..3.
  - Plaintext words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required output: m_data 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, m_last on the 4th word, one core_start pulse.
- FIPS-197 App. B, key reloaded:
  - Key 2b7e1516 28aed2a6 abf71588 09cf4f3c; plaintext 3243f6a8 885a308d 313198a2 e0370734.
  - Required output: 3925841d 02dc09fb dc118597 196a0b32.
- No key loaded:
  - Drive only idx 0..2, then hold s_valid = 1.
  - Required: s_ready stays 0, core_start never asserts.
  - Write idx 3 → s_ready rises the next cycle.
- Backpressure:
  - Hold m_ready low for 5 cycles during DRAIN.
  - Required: m_data stays 69c4e0d8 with m_valid high; words resume in order, none lost or duplicated.
- Timeout, stub core that never asserts ready, TIMEOUT=16:
  - Required: err_timeout rises 16 cycles after core_start; state returns to IDLE, s_ready = 1.
  - The next block with a working stub completes normally and err_timeout stays 1.
- Reset mid-WAIT, plus key write during WAIT:
  - Key write during WAIT: core_key remains unchanged.
  - Assert reset during WAIT: all outputs 0, key_loaded = 0.
  - A late core_ready after reset produces no m_valid.
